ristretto_pipe_ctrl: RTL and testbench

RISTRETTO_PIPE_CTRL -- requirements
Module: ristretto_pipe_ctrl

---
 rtl/ristretto_pipe_ctrl_pkg.sv | 30 +++
 rtl/ristretto_hazard_cmp.sv | 33 +++
 rtl/ristretto_pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_ristretto_pipe_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ristretto_pipe_ctrl_pkg.sv
// Shared types and constants for the ristretto pipeline controller:
// FSM state encoding, forwarding-select encoding and squash-length bounds.
package ristretto_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HAZ_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // forward_src bit0 replaces operand A (rs1), bit1 replaces operand B (rs2)
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_A    = 2'b01;
    localparam logic [1:0] FWD_B    = 2'b10;
    localparam logic [1:0] FWD_AB   = 2'b11;

    localparam int FLUSH_CYCLES_MIN = 1;
    localparam int FLUSH_CYCLES_MAX = 3;
    localparam int FLUSH_CNT_W      = 2;

    // Counter preload for a redirect; out-of-range lengths are clamped.
    function automatic logic [FLUSH_CNT_W-1:0] flush_load(input int cycles);
        int c;
        c = cycles;
        if (c < FLUSH_CYCLES_MIN) c = FLUSH_CYCLES_MIN;
        if (c > FLUSH_CYCLES_MAX) c = FLUSH_CYCLES_MAX;
        return FLUSH_CNT_W'(c - 1);
    endfunction

endpackage

// File: rtl/ristretto_hazard_cmp.sv
// Compares the decode source registers against the single in-flight
// write record and reports a per-source read-after-write match.
module ristretto_hazard_cmp #(
    parameter int AddrWidth = 5
) (
    input  logic [AddrWidth-1:0] rs1,
    input  logic [AddrWidth-1:0] rs2,
    input  logic                 uses_rs1,
    input  logic                 uses_rs2,
    input  logic                 busy,
    input  logic [AddrWidth-1:0] rd,
    output logic                 match1,
    output logic                 match2
);

    logic [AddrWidth-1:0] src_addr [2];
    logic [1:0]           src_uses;
    logic [1:0]           hit;

    assign src_addr[0] = rs1;
    assign src_addr[1] = rs2;
    assign src_uses    = {uses_rs2, uses_rs1};

    // x0 is hardwired zero, so it never carries a hazard
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign hit[gi] = src_uses[gi] && busy &&
                         (src_addr[gi] != '0) && (src_addr[gi] == rd);
    end

    assign match1 = hit[0];
    assign match2 = hit[1];

endmodule

// File: rtl/ristretto_pipe_ctrl.sv
// Decode/exe pipeline controller: RAW hazard stall with same-cycle
// write-back forwarding, plus a fixed-length decode squash after redirects.
module ristretto_pipe_ctrl
    import ristretto_pipe_ctrl_pkg::*;
#(
    parameter int RegAddrWidth = 5,
    parameter int FlushCycles  = 1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    dec_new_instr_i,
    input  logic [RegAddrWidth-1:0] dec_rsrc1_addr_i,
    input  logic [RegAddrWidth-1:0] dec_rsrc2_addr_i,
    input  logic                    dec_uses_rs1_i,
    input  logic                    dec_uses_rs2_i,
    input  logic [RegAddrWidth-1:0] dec_rd_addr_i,
    input  logic                    dec_rd_we_i,
    input  logic                    exe_wb_valid_i,
    input  logic                    exe_redirect_i,
    output logic                    issue_o,
    output logic                    stall_o,
    output logic                    flush_o,
    output logic                    forward_en_o,
    output logic [1:0]              forward_src_o,
    output logic [1:0]              state_o
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = flush_load(FlushCycles);

    state_t                  state_reg, state_next;
    logic                    busy_reg, busy_next;
    logic [RegAddrWidth-1:0] rd_reg, rd_next;
    logic [FLUSH_CNT_W-1:0]  cnt_reg, cnt_next;

    logic       match1, match2;
    logic       issue, stall, flush, fwd_en;
    logic [1:0] fwd_src;

    ristretto_hazard_cmp #(
        .AddrWidth (RegAddrWidth)
    ) u_hazard_cmp (
        .rs1      (dec_rsrc1_addr_i),
        .rs2      (dec_rsrc2_addr_i),
        .uses_rs1 (dec_uses_rs1_i),
        .uses_rs2 (dec_uses_rs2_i),
        .busy     (busy_reg),
        .rd       (rd_reg),
        .match1   (match1),
        .match2   (match2)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b0;
            rd_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= busy_next;
            rd_reg    <= rd_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        issue      = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        fwd_en     = 1'b0;
        fwd_src    = FWD_NONE;
        if (exe_redirect_i) begin
            flush      = 1'b1;
            cnt_next   = FLUSH_LOAD;
            state_next = (FLUSH_LOAD == '0) ? ST_RUN : ST_FLUSH;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (!(match1 || match2)) begin
                        issue = dec_new_instr_i;
                    end else if (exe_wb_valid_i) begin
                        issue   = 1'b1;
                        fwd_en  = 1'b1;
                        fwd_src = {match2, match1};
                    end else begin
                        stall      = 1'b1;
                        state_next = ST_HAZ_WAIT;
                    end
                end
                ST_HAZ_WAIT: begin
                    // decode is frozen here, so the match seen on entry still holds
                    if (exe_wb_valid_i) begin
                        issue      = 1'b1;
                        fwd_en     = match1 || match2;
                        fwd_src    = {match2, match1};
                        state_next = ST_RUN;
                    end else begin
                        stall = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush = 1'b1;
                    if (cnt_reg <= FLUSH_CNT_W'(1)) begin
                        cnt_next   = '0;
                        state_next = ST_RUN;
                    end else begin
                        cnt_next = cnt_reg - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // A new write issued in the same cycle as a write-back keeps the record busy
    always_comb begin
        busy_next = busy_reg;
        rd_next   = rd_reg;
        if (issue && dec_rd_we_i && (dec_rd_addr_i != '0)) begin
            busy_next = 1'b1;
            rd_next   = dec_rd_addr_i;
        end else if (exe_wb_valid_i) begin
            busy_next = 1'b0;
        end
    end

    assign issue_o       = issue  && rstn_i;
    assign stall_o       = stall  && rstn_i;
    assign flush_o       = flush  && rstn_i;
    assign forward_en_o  = fwd_en && rstn_i;
    assign forward_src_o = fwd_src & {2{rstn_i}};
    assign state_o       = state_reg;

endmodule

// File: tb/tb_ristretto_pipe_ctrl.sv
// Self-checking bench for ristretto_pipe_ctrl: directed vector table,
// async-reset sequence, then random traffic against a behavioural model.
module tb_ristretto_pipe_ctrl;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       dec_new_instr;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;
    logic       uses_rs1, uses_rs2, rd_we, wb_valid, redirect;
    logic       issue, stall, flush, fwd_en;
    logic [1:0] fwd_src, state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       nw;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       wb;
        logic       redir;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    // behavioural model state
    bit m_busy;
    int m_rd;
    bit m_wait;
    int m_flush_left;

    ristretto_pipe_ctrl #(
        .RegAddrWidth (5),
        .FlushCycles  (FC)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .dec_new_instr_i  (dec_new_instr),
        .dec_rsrc1_addr_i (rs1_addr),
        .dec_rsrc2_addr_i (rs2_addr),
        .dec_uses_rs1_i   (uses_rs1),
        .dec_uses_rs2_i   (uses_rs2),
        .dec_rd_addr_i    (rd_addr),
        .dec_rd_we_i      (rd_we),
        .exe_wb_valid_i   (wb_valid),
        .exe_redirect_i   (redirect),
        .issue_o          (issue),
        .stall_o          (stall),
        .flush_o          (flush),
        .forward_en_o     (fwd_en),
        .forward_src_o    (fwd_src),
        .state_o          (state)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic nw, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic we, input logic wb, input logic redir);
        stim_t s;
        s.nw = nw; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
        s.rd = rd; s.we = we; s.wb = wb; s.redir = redir;
        return s;
    endfunction

    task automatic add(input string name, input stim_t s, input logic [7:0] exp);
        vec_t v;
        v.name = name; v.s = s; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic apply(input stim_t s);
        dec_new_instr = s.nw;
        rs1_addr      = s.rs1;
        uses_rs1      = s.u1;
        rs2_addr      = s.rs2;
        uses_rs2      = s.u2;
        rd_addr       = s.rd;
        rd_we         = s.we;
        wb_valid      = s.wb;
        redirect      = s.redir;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {issue, stall, flush, fwd_en, fwd_src, state};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {issue,stall,flush,fwd_en,fwd_src,state}=%b required=%b",
                     name, got, exp);
        end
        else
            $display("[TB] ok   %s outs=%b", name, got);
    endtask

    // Reference: a source hazards when it is read, non-zero, and names the pending write
    function automatic bit src_hit(input logic [4:0] a, input logic u);
        return u && (a != 0) && m_busy && (int'(a) == m_rd);
    endfunction

    function automatic logic [7:0] model_eval(input stim_t s);
        bit iss, stl, fl, fen;
        bit [1:0] src;
        int st;
        bit h1, h2;
        iss = 0; stl = 0; fl = 0; fen = 0; src = 2'b00;
        h1 = src_hit(s.rs1, s.u1);
        h2 = src_hit(s.rs2, s.u2);
        st = (m_flush_left > 0) ? 2 : (m_wait ? 1 : 0);
        if (s.redir || m_flush_left > 0) begin
            fl = 1;
        end else if (m_wait || h1 || h2) begin
            if (s.wb) begin
                iss = 1;
                src = {h2, h1};
                fen = h1 || h2;
            end else begin
                stl = 1;
            end
        end else begin
            iss = s.nw;
        end
        return {iss, stl, fl, fen, src, 2'(st)};
    endfunction

    task automatic model_advance(input stim_t s, input logic [7:0] exp);
        bit any_hit;
        any_hit = src_hit(s.rs1, s.u1) || src_hit(s.rs2, s.u2);
        if (s.redir) begin
            m_flush_left = FC - 1;
            m_wait       = 0;
        end else if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end else if (m_wait) begin
            if (s.wb) m_wait = 0;
        end else if (any_hit && !s.wb) begin
            m_wait = 1;
        end
        if (exp[7] && s.we && s.rd != 0) begin
            m_busy = 1;
            m_rd   = int'(s.rd);
        end else if (s.wb) begin
            m_busy = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        logic [7:0] e;

        //      name             nw    rs1   u1    rs2   u2    rd    we    wb    redir   {iss,stl,fl,fen,src,st}
        add("idle",          mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 8'b0000_0000);
        add("addi_x5",       mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0), 8'b1000_0000);
        add("add_stall_c1",  mk(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0), 8'b0100_0000);
        add("add_stall_c2",  mk(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0), 8'b0100_0001);
        add("add_fwd_a",     mk(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0), 8'b1001_0101);
        add("drain_x6",      mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), 8'b0000_0000);
        add("read_x0",       mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), 8'b1000_0000);
        add("set_x7",        mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0), 8'b1000_0000);
        add("dual_fwd_x7",   mk(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0), 8'b1001_1100);
        add("set_x2",        mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0), 8'b1000_0000);
        add("wb_and_set_x3", mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0), 8'b1000_0000);
        add("probe_x3",      mk(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), 8'b0100_0000);
        add("haz_redirect",  mk(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1), 8'b0010_0001);
        add("flush_tail",    mk(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), 8'b0010_0010);
        add("still_busy_x3", mk(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), 8'b0100_0000);
        add("release_x3",    mk(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0), 8'b1001_1001);
        add("set_x9",        mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0), 8'b1000_0000);
        add("redir_with_wb", mk(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1), 8'b0010_0000);
        add("flush_x9",      mk(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 8'b0010_0010);
        add("x9_cleared",    mk(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 8'b1000_0000);
        add("redir_a",       mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1), 8'b0010_0000);
        add("redir_reload",  mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1), 8'b0010_0010);
        add("reload_tail",   mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 8'b0010_0010);
        add("back_run",      mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 8'b1000_0000);

        // reset with a new instruction pending: every output must still read 0
        rstn = 1'b0;
        apply(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 8'b0000_0000);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s);
            #2;
            check(tbl[i].name, tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // asynchronous reset while parked in HAZ_WAIT
        apply(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0));
        #2; check("set_x4", 8'b1000_0000);
        @(posedge clk); #1;
        apply(mk(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
        #2; check("probe_x4_c1", 8'b0100_0000);
        @(posedge clk); #1;
        #2; check("probe_x4_c2", 8'b0100_0001);
        wb_valid = 1'b1;
        #1; check("haz_wb_visible", 8'b1001_0101);
        rstn = 1'b0;
        #1; check("async_reset", 8'b0000_0000);
        @(posedge clk); #1;
        rstn = 1'b1;
        apply(mk(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
        #2; check("post_reset_run", 8'b1000_0000);
        @(posedge clk); #1;

        // random traffic against the reference model, starting from an empty record
        m_busy = 0; m_rd = 0; m_wait = 0; m_flush_left = 0;
        for (int i = 0; i < 3000; i++) begin
            s.nw    = ($urandom_range(0, 3) != 0);
            s.rs1   = 5'($urandom_range(0, 7));
            s.u1    = ($urandom_range(0, 1) != 0);
            s.rs2   = 5'($urandom_range(0, 7));
            s.u2    = ($urandom_range(0, 1) != 0);
            s.rd    = 5'($urandom_range(0, 7));
            s.we    = ($urandom_range(0, 2) != 0);
            s.wb    = ($urandom_range(0, 2) == 0);
            s.redir = ($urandom_range(0, 11) == 0);
            e = model_eval(s);
            apply(s);
            #2;
            check($sformatf("rand%0d", i), e);
            model_advance(s, e);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
